code_lock: RTL
==============

CODE_LOCK -- requirements
Module: code_lock

Interface
REQ-001 SHALL have parameter SYM_W, default 4: bits per code symbol.
REQ-002 SHALL have parameter CODE_LEN, default 4: symbols per code, range 2..16.
REQ-003 SHALL have parameter MAX_FAIL, default 3: consecutive wrong entries before lockout, range 1..15.
REQ-004 SHALL have parameter UNLOCK_CYC, default 8: unlock hold time in clk cycles, >=1.
REQ-005 SHALL have parameter LOCKOUT_CYC, default 16: lockout time in clk cycles, >=1.
REQ-006 SHALL have parameter DEFAULT_CODE, width SYM_W*CODE_LEN, default 16'h4321: code loaded at reset.
REQ-007 SHALL have port clk, input, 1 bit: the only clock; all logic on its rising edge.
REQ-008 SHALL have port reset_n, input, 1 bit: synchronous active-low reset.
REQ-009 SHALL have port sym_in, input, SYM_W bits: entered symbol.
REQ-010 SHALL have port sym_valid, input, 1 bit: sym_in is sampled on each cycle this is high.
REQ-011 SHALL have port clear, input, 1 bit: abandons the entry in progress.
REQ-012 SHALL have port prog_en, input, 1 bit: request to load a new code.
REQ-013 SHALL have port prog_code, input, SYM_W*CODE_LEN bits: new code value.
REQ-014 SHALL have port unlocked, output, 1 bit: door open.
REQ-015 SHALL have port lockout, output, 1 bit: entry is disabled.
REQ-016 SHALL have port fail_pulse, output, 1 bit: one-cycle pulse on each wrong entry.
REQ-017 SHALL have port fail_cnt, output, 4 bits: current consecutive-failure count.

Function
REQ-018 SHALL implement a three-state FSM: ENTRY, UNLOCK and LOCKOUT; all outputs are registered.
REQ-019 SHALL compare the k-th accepted symbol (k = 0..CODE_LEN-1) against stored_code[k*SYM_W +: SYM_W], and SHALL keep a running all-match flag.
REQ-020 SHALL evaluate the entry only when the CODE_LEN-th symbol is accepted; no early rejection; any sequence of CODE_LEN symbols is a complete entry.
REQ-021 SHALL, on a correct entry, go to UNLOCK; unlocked rises the cycle after the last symbol is sampled, stays high exactly UNLOCK_CYC cycles, then the FSM returns to ENTRY; fail_cnt is cleared to 0.
REQ-022 SHALL, on a wrong entry, pulse fail_pulse for one cycle the cycle after the last symbol and increment fail_cnt.
REQ-023 SHALL, when fail_cnt would reach MAX_FAIL, go to LOCKOUT instead of ENTRY; lockout rises in the same cycle as fail_pulse and stays high exactly LOCKOUT_CYC cycles; on exit fail_cnt is 0 and the FSM is in ENTRY.
REQ-024 SHALL ignore sym_valid and clear in UNLOCK and LOCKOUT; the entry counter and match flag are reset on entering ENTRY.
REQ-025 SHALL, on clear in ENTRY, discard the partial entry without counting a failure; when clear and sym_valid are high in the same cycle, clear wins and the symbol is dropped.
REQ-026 SHALL accept prog_en only in UNLOCK: stored_code takes prog_code on the next edge; the unlock timer is unaffected; prog_en is ignored in other states.
REQ-027 SHALL accept back-to-back symbols on consecutive cycles; sym_valid may be high on the cycle UNLOCK or LOCKOUT ends, and that symbol is ignored (the first accepted symbol comes one cycle after re-entering ENTRY).
REQ-028 SHALL keep fail_cnt saturating at MAX_FAIL; fail_cnt never wraps.

Reset
REQ-029 SHALL, when reset_n is low at a clk edge, set FSM=ENTRY, entry count=0, match flag=1, stored_code=DEFAULT_CODE, unlocked=0, lockout=0, fail_pulse=0 and fail_cnt=0, from any state, including mid-entry, UNLOCK and LOCKOUT.
REQ-030 SHALL lose a code loaded via prog_en on reset.

Verification
REQ-031 SHALL check correct entry: defaults; symbols 1,2,3,4 on consecutive cycles -> unlocked high for 8 cycles starting the cycle after symbol 4; fail_cnt=0.
REQ-032 SHALL check a wrong entry: symbols 1,2,3,5 -> fail_pulse for 1 cycle, fail_cnt=1, unlocked stays 0.
REQ-033 SHALL check lockout: three wrong entries -> lockout=1 for 16 cycles with the 3rd fail_pulse; the entry 1,2,3,4 during lockout is ignored; after lockout fail_cnt=0.
REQ-034 SHALL check clear: 1,2 then clear then 1,2,3,4 -> unlock and no fail_pulse; clear and sym_valid in the same cycle -> symbol dropped.
REQ-035 SHALL check reprogramming: unlock, then prog_en with prog_code=16'h8765 -> unlock still ends after 8 cycles; 1,2,3,4 then fails; 5,6,7,8 unlocks; after reset, 1,2,3,4 unlocks again.
REQ-036 SHALL check reset mid-operation: reset_n low during UNLOCK and during LOCKOUT -> all outputs 0 on the next edge; the code returns to DEFAULT_CODE.

Source files
------------

// File: rtl/code_lock.sv
// Symbol-entry code lock: compares CODE_LEN symbols against a stored code,
// opens for UNLOCK_CYC cycles on a match, and locks out after MAX_FAIL misses.
module code_lock #(
    parameter int                          SYM_W        = 4,
    parameter int                          CODE_LEN     = 4,
    parameter int                          MAX_FAIL     = 3,
    parameter int                          UNLOCK_CYC   = 8,
    parameter int                          LOCKOUT_CYC  = 16,
    parameter logic [SYM_W*CODE_LEN-1:0]   DEFAULT_CODE = 16'h4321
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [SYM_W-1:0]          sym_in,
    input  logic                      sym_valid,
    input  logic                      clear,
    input  logic                      prog_en,
    input  logic [SYM_W*CODE_LEN-1:0] prog_code,
    output logic                      unlocked,
    output logic                      lockout,
    output logic                      fail_pulse,
    output logic [3:0]                fail_cnt
);

    localparam int MAX_CYC = (UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC;
    localparam int TMR_W   = $clog2(MAX_CYC + 1);
    localparam int CNT_W   = $clog2(CODE_LEN);

    localparam logic [CNT_W-1:0] LAST_IDX     = CNT_W'(CODE_LEN - 1);
    localparam logic [TMR_W-1:0] UNLOCK_LOAD  = TMR_W'(UNLOCK_CYC - 1);
    localparam logic [TMR_W-1:0] LOCKOUT_LOAD = TMR_W'(LOCKOUT_CYC - 1);
    localparam logic [3:0]       MAX_FAIL_C   = 4'(MAX_FAIL);

    typedef enum logic [1:0] {
        ST_ENTRY,
        ST_UNLOCK,
        ST_LOCKOUT
    } state_t;

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            ent_cnt_q, ent_cnt_d;
    logic                        match_q, match_d;
    logic [SYM_W*CODE_LEN-1:0]   code_q, code_d;
    logic [TMR_W-1:0]            tmr_q, tmr_d;
    logic                        unlocked_q, unlocked_d;
    logic                        lockout_q, lockout_d;
    logic                        fail_pulse_q, fail_pulse_d;
    logic [3:0]                  fail_cnt_q, fail_cnt_d;

    logic [SYM_W-1:0]            exp_sym;
    logic                        sym_ok;
    logic [3:0]                  fail_next;

    always_comb begin
        exp_sym   = code_q[int'(ent_cnt_q)*SYM_W +: SYM_W];
        sym_ok    = (sym_in == exp_sym);
        fail_next = (fail_cnt_q < MAX_FAIL_C) ? fail_cnt_q + 4'd1 : fail_cnt_q;
    end

    always_comb begin
        state_d      = state_q;
        ent_cnt_d    = ent_cnt_q;
        match_d      = match_q;
        code_d       = code_q;
        tmr_d        = tmr_q;
        unlocked_d   = unlocked_q;
        lockout_d    = lockout_q;
        fail_pulse_d = 1'b0;
        fail_cnt_d   = fail_cnt_q;

        case (state_q)
            ST_ENTRY: begin
                // clear has priority: the coincident symbol is dropped
                if (clear) begin
                    ent_cnt_d = '0;
                    match_d   = 1'b1;
                end else if (sym_valid) begin
                    if (ent_cnt_q == LAST_IDX) begin
                        ent_cnt_d = '0;
                        match_d   = 1'b1;
                        if (match_q && sym_ok) begin
                            state_d    = ST_UNLOCK;
                            unlocked_d = 1'b1;
                            tmr_d      = UNLOCK_LOAD;
                            fail_cnt_d = 4'd0;
                        end else begin
                            fail_pulse_d = 1'b1;
                            fail_cnt_d   = fail_next;
                            if (fail_next >= MAX_FAIL_C) begin
                                state_d   = ST_LOCKOUT;
                                lockout_d = 1'b1;
                                tmr_d     = LOCKOUT_LOAD;
                            end
                        end
                    end else begin
                        ent_cnt_d = ent_cnt_q + 1'b1;
                        match_d   = match_q & sym_ok;
                    end
                end
            end
            ST_UNLOCK: begin
                if (prog_en) begin
                    code_d = prog_code;
                end
                if (tmr_q == '0) begin
                    state_d    = ST_ENTRY;
                    unlocked_d = 1'b0;
                    ent_cnt_d  = '0;
                    match_d    = 1'b1;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            ST_LOCKOUT: begin
                if (tmr_q == '0) begin
                    state_d    = ST_ENTRY;
                    lockout_d  = 1'b0;
                    fail_cnt_d = 4'd0;
                    ent_cnt_d  = '0;
                    match_d    = 1'b1;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: begin
                state_d    = ST_ENTRY;
                unlocked_d = 1'b0;
                lockout_d  = 1'b0;
                ent_cnt_d  = '0;
                match_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_ENTRY;
            ent_cnt_q    <= '0;
            match_q      <= 1'b1;
            code_q       <= DEFAULT_CODE;
            tmr_q        <= '0;
            unlocked_q   <= 1'b0;
            lockout_q    <= 1'b0;
            fail_pulse_q <= 1'b0;
            fail_cnt_q   <= 4'd0;
        end else begin
            state_q      <= state_d;
            ent_cnt_q    <= ent_cnt_d;
            match_q      <= match_d;
            code_q       <= code_d;
            tmr_q        <= tmr_d;
            unlocked_q   <= unlocked_d;
            lockout_q    <= lockout_d;
            fail_pulse_q <= fail_pulse_d;
            fail_cnt_q   <= fail_cnt_d;
        end
    end

    assign unlocked   = unlocked_q;
    assign lockout    = lockout_q;
    assign fail_pulse = fail_pulse_q;
    assign fail_cnt   = fail_cnt_q;

endmodule
